load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES SHALL be: default 255, meaning the max cycles spent in REQ+WAIT before bus error (legal range 1..255).
REQ-002 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  SHALL be a synchronous, active-low reset.
REQ-004 mem_read, mem_write  in  1 each  SHALL be pipeline strobes requesting a load or store.
REQ-005 addr  in  32  SHALL be the byte address computed by the ALU.
REQ-006 wdata  in  32  SHALL be the store data (rs2).
REQ-007 readdatasel  in  3  SHALL select the load type: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; 101-111 treated as lw.
REQ-008 writedatasel  in  2  SHALL select the store type: 00 sw, 01 sb, 10 sh; 11 treated as sw.
REQ-009 mem_req, mem_we  out  1 each  SHALL be the bus request and write enable.
REQ-010 mem_addr  out  32  SHALL be the word address, {addr[31:2],2'b00}.
REQ-011 mem_be  out  4  SHALL be the byte enables.
REQ-012 mem_wdata  out  32  SHALL be the lane-replicated store data.
REQ-013 mem_gnt, mem_rvalid  in  1 each  SHALL be the request accept and the response valid (response applies to reads and writes).
REQ-014 mem_rdata  in  32  SHALL be the read data, valid with mem_rvalid.
REQ-015 stall  out  1, done  out  1, rdata  out  32, bus_err  out  1, misalign  out  1  SHALL be the pipeline-side status and formatted load data.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-017 IDLE->REQ SHALL occur when mem_read|mem_write is sampled; addr, wdata, sel fields and direction are captured at that edge.
REQ-018 When both strobes are high, the write SHALL win.
REQ-019 In REQ, mem_req SHALL be held high with stable addr/be/wdata/we until mem_gnt; gnt alone ->WAIT; gnt with mem_rvalid in the same cycle ->DONE.
REQ-020 In WAIT, mem_rvalid SHALL move the FSM to DONE; mem_req is low in WAIT.
REQ-021 DONE SHALL last exactly one cycle with done=1 and then return to IDLE; strobes sampled in DONE are ignored.
REQ-022 stall SHALL equal (state==IDLE && (mem_read|mem_write)) || state==REQ || state==WAIT; it is 0 in DONE.
REQ-023 Store lanes SHALL be: sb be=4'b0001<<addr[1:0] with wdata={4{wdata[7:0]}}; sh be=4'b0011<<{addr[1],1'b0} with wdata={2{wdata[15:0]}}; sw be=4'hF with wdata unchanged.
REQ-024 Loads SHALL drive be=4'hF and mem_we=0.
REQ-025 rdata SHALL be registered on the accepting mem_rvalid edge:
- lb/lbu: byte addr[1:0], sign- or zero-extended.
- lh/lhu: half addr[1], sign- or zero-extended.
- lw: full word.
REQ-026 For stores, rdata SHALL be 0.
REQ-027 The minimum load latency SHALL be 3 cycles from the strobe sample to done, when gnt and rvalid arrive on the first REQ cycle.
REQ-028 An 8-bit counter SHALL clear on entry to REQ and increment each REQ/WAIT cycle.
REQ-029 When the counter reaches TIMEOUT_CYCLES, the FSM SHALL go ->DONE with bus_err=1 and rdata=0.
REQ-030 If mem_rvalid arrives in the same cycle as the timeout, mem_rvalid SHALL win and bus_err SHALL be 0.
REQ-031 bus_err and misalign SHALL be valid only with done and SHALL be 0 otherwise.

Reset
REQ-032 While rst_n=0, the next edge SHALL force: IDLE; mem_req, mem_we, done, bus_err, misalign = 0; mem_addr, mem_be, mem_wdata, rdata, counter = 0.
REQ-033 stall SHALL be 0 while rst_n=0.
REQ-034 Reset mid-transaction SHALL abandon it with no done pulse, and a late mem_rvalid after reset SHALL be ignored in IDLE.

Configuration
REQ-035 Macro LSU_MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL go IDLE->DONE directly with misalign=1, no mem_req, and rdata=0.
REQ-036 Macro LSU_MISALIGN_TRAP_EN undefined: misalign SHALL be tied 0, halfword ignores addr[0], word ignores addr[1:0], and the access is issued normally.

Verification
REQ-037 lb at addr 0x103, mem_rdata 0x80AABBCC, gnt+rvalid on first REQ cycle -> done 3 cycles after strobe, rdata=0xFFFFFF80.
REQ-038 sh at addr 0x202, wdata 0x1234ABCD, gnt after 2 cycles -> mem_req held 3 cycles, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200.
REQ-039 lhu at addr 0x4 with no response, TIMEOUT_CYCLES=4 -> done with bus_err=1, rdata=0 after 4 REQ/WAIT cycles.
REQ-040 lw at addr 0x6: with LSU_MISALIGN_TRAP_EN -> no mem_req, done+misalign next cycle; without it -> mem_addr=0x4 issued, misalign=0.
REQ-041 rst_n=0 asserted in WAIT, then mem_rvalid=1 after release -> no done, state IDLE, all outputs 0.
REQ-042 mem_read and mem_write both high, sb at 0x1 -> mem_we=1, mem_be=4'b0010.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: captures a pipeline load/store, runs one bus transaction with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  readdatasel,
    input  logic [1:0]  writedatasel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [7:0] TIMEOUT_LIM = TIMEOUT_CYCLES[7:0];

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic        is_write_q;
    logic [2:0]  rsel_q;
    logic [1:0]  addr_lo_q;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic        start;
    logic        acc_ok;
    logic        acc_to;
    logic        trap;

    always_comb begin
        st_be    = 4'hF;
        st_wdata = wdata;
        case (writedatasel)
            2'b01: begin
                st_be    = 4'b0001 << addr[1:0];
                st_wdata = {4{wdata[7:0]}};
            end
            2'b10: begin
                st_be    = 4'b0011 << {addr[1], 1'b0};
                st_wdata = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (rsel_q)
            3'b001:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b010:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b011:  ld_data = {24'd0, ld_byte};
            3'b100:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // A response in the timeout cycle still counts as a successful access.
    always_comb begin
        start    = (state == S_IDLE) && (mem_read || mem_write);
        cnt_next = cnt + 8'd1;
        acc_ok   = ((state == S_REQ) && mem_gnt && mem_rvalid) ||
                   ((state == S_WAIT) && mem_rvalid);
        acc_to   = ((state == S_REQ) || (state == S_WAIT)) && !acc_ok &&
                   (cnt_next == TIMEOUT_LIM);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;

    always_comb begin
        trap = 1'b0;
        if (mem_write) begin
            case (writedatasel)
                2'b01:   trap = 1'b0;
                2'b10:   trap = addr[0];
                default: trap = (addr[1:0] != 2'b00);
            endcase
        end else begin
            case (readdatasel)
                3'b001, 3'b011: trap = 1'b0;
                3'b010, 3'b100: trap = addr[0];
                default:        trap = (addr[1:0] != 2'b00);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            misalign_q <= 1'b0;
        else if (start && trap)
            misalign_q <= 1'b1;
        else if (state == S_DONE)
            misalign_q <= 1'b0;
    end

    assign misalign = misalign_q;
`else
    assign trap     = 1'b0;
    assign misalign = 1'b0;
`endif

    assign stall = rst_n && (start || (state == S_REQ) || (state == S_WAIT));
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            is_write_q <= 1'b0;
            rsel_q     <= '0;
            addr_lo_q  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_write_q <= mem_write;
                        rsel_q     <= readdatasel;
                        addr_lo_q  <= addr[1:0];
                        cnt        <= '0;
                        if (trap) begin
                            state <= S_DONE;
                            rdata <= '0;
                        end else begin
                            state     <= S_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= mem_write;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= mem_write ? st_be : 4'hF;
                            mem_wdata <= mem_write ? st_wdata : '0;
                        end
                    end
                end
                S_REQ, S_WAIT: begin
                    cnt <= cnt_next;
                    if (acc_ok || acc_to) begin
                        state   <= S_DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= acc_to;
                        rdata   <= (acc_ok && !is_write_q) ? ld_data : '0;
                    end else if ((state == S_REQ) && mem_gnt) begin
                        state   <= S_WAIT;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    bus_err <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  readdatasel;
    logic [1:0]  writedatasel;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall, done, bus_err, misalign;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .readdatasel(readdatasel), .writedatasel(writedatasel),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall(stall), .done(done), .rdata(rdata),
        .bus_err(bus_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
        readdatasel = '0; writedatasel = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        mem_read = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_req_we: got %b%b expected 00", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h %h %h expected zeros", mem_addr, mem_be, mem_wdata); end
        checks++; if (rdata !== 32'h0 || done !== 1'b0 || bus_err !== 1'b0 || misalign !== 1'b0) begin errors++; $display("FAIL reset_status: got %h %b%b%b expected zeros", rdata, done, bus_err, misalign); end
        mem_read = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lb_min_latency();
        mem_read = 1'b1; readdatasel = 3'b001; addr = 32'h103;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lb_idle_stall: got %b expected 1", stall); end
        step();
        mem_read = 1'b0;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lb_req: got req=%b we=%b expected req=1 we=0", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h100 || mem_be !== 4'hF) begin errors++; $display("FAIL lb_addr_be: got %h %h expected 00000100 f", mem_addr, mem_be); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h80AABBCC;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL lb_done: got done=%b stall=%b expected 1 0", done, stall); end
        checks++; if (rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata: got %h expected ffffff80", rdata); end
        checks++; if (mem_req !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL lb_post: got req=%b err=%b expected 0 0", mem_req, bus_err); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL lb_done_one_cycle: got %b expected 0", done); end
    endtask

    task automatic test_timeout();
        mem_read = 1'b1; readdatasel = 3'b100; addr = 32'h4;
        step();
        mem_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem_req !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL timeout_wait_%0d: got req=%b done=%b expected 1 0", i, mem_req, done); end
            step();
        end
        checks++; if (done !== 1'b1 || bus_err !== 1'b1) begin errors++; $display("FAIL timeout_done: got done=%b err=%b expected 1 1", done, bus_err); end
        checks++; if (rdata !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL timeout_rdata: got %h req=%b expected 0 0", rdata, mem_req); end
        step();
        checks++; if (done !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL timeout_clear: got done=%b err=%b expected 0 0", done, bus_err); end
    endtask

    task automatic test_sh_hold();
        mem_write = 1'b1; writedatasel = 2'b10; addr = 32'h202; wdata = 32'h1234ABCD;
        step();
        mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100) begin errors++; $display("FAIL sh_req_%0d: got req=%b we=%b be=%b expected 1 1 1100", i, mem_req, mem_we, mem_be); end
            checks++; if (mem_wdata !== 32'hABCDABCD || mem_addr !== 32'h200) begin errors++; $display("FAIL sh_data_%0d: got %h %h expected abcdabcd 00000200", i, mem_wdata, mem_addr); end
            if (i == 2) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sh_wait: got req=%b stall=%b done=%b expected 0 1 0", mem_req, stall, done); end
        // fourth REQ/WAIT cycle: response coincides with the timeout
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || bus_err !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL sh_done: got done=%b err=%b rdata=%h expected 1 0 0", done, bus_err, rdata); end
        step();
    endtask

    task automatic test_load_formats();
        logic [2:0]  sels [5] = '{3'b010, 3'b100, 3'b011, 3'b001, 3'b111};
        logic [31:0] adrs [5] = '{32'h102, 32'h100, 32'h101, 32'h100, 32'h108};
        logic [31:0] rds  [5] = '{32'h80017FFF, 32'h1234F00D, 32'h000080FF, 32'h0000007F, 32'hCAFEBABE};
        logic [31:0] exps [5] = '{32'hFFFF8001, 32'h0000F00D, 32'h00000080, 32'h0000007F, 32'hCAFEBABE};
        for (int i = 0; i < 5; i++) begin
            mem_read = 1'b1; readdatasel = sels[i]; addr = adrs[i];
            step();
            mem_read = 1'b0; mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL fmt_wait_%0d: got req=%b stall=%b expected 0 1", i, mem_req, stall); end
            mem_rvalid = 1'b1; mem_rdata = rds[i];
            step();
            mem_rvalid = 1'b0;
            checks++; if (done !== 1'b1 || rdata !== exps[i]) begin errors++; $display("FAIL fmt_rdata_%0d: got done=%b rdata=%h expected 1 %h", i, done, rdata, exps[i]); end
            step();
        end
    endtask

    task automatic test_misaligned_lw();
        mem_read = 1'b1; readdatasel = 3'b000; addr = 32'h6;
        step();
        mem_read = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (done !== 1'b1 || misalign !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL mis_trap: got done=%b mis=%b req=%b expected 1 1 0", done, misalign, mem_req); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mis_rdata: got %h expected 0", rdata); end
        step();
        checks++; if (misalign !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mis_clear: got mis=%b done=%b expected 0 0", misalign, done); end
`else
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4 || misalign !== 1'b0) begin errors++; $display("FAIL mis_issue: got req=%b addr=%h mis=%b expected 1 00000004 0", mem_req, mem_addr, misalign); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || rdata !== 32'hDEADBEEF || misalign !== 1'b0) begin errors++; $display("FAIL mis_done: got done=%b rdata=%h mis=%b expected 1 deadbeef 0", done, rdata, misalign); end
        step();
`endif
    endtask

    task automatic test_both_strobes();
        mem_read = 1'b1; mem_write = 1'b1; writedatasel = 2'b01; readdatasel = 3'b000;
        addr = 32'h1; wdata = 32'h000000A5;
        step();
        mem_read = 1'b0; mem_write = 1'b0;
        checks++; if (mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL both_store: got we=%b be=%b wd=%h expected 1 0010 a5a5a5a5", mem_we, mem_be, mem_wdata); end
        mem_gnt = 1'b1; mem_rvalid = 1'b1;
        step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        checks++; if (done !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL both_done: got done=%b stall=%b expected 1 0", done, stall); end
        mem_read = 1'b1; addr = 32'h20;
        step();
        checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL done_ignores_strobe: got req=%b done=%b expected 0 0", mem_req, done); end
        mem_read = 1'b0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b expected 0", stall); end
    endtask

    task automatic test_reset_mid();
        mem_read = 1'b1; readdatasel = 3'b000; addr = 32'h10;
        step();
        mem_read = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        step();
        mem_rvalid = 1'b0;
        checks++; if (done !== 1'b0 || stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_status: got done=%b stall=%b req=%b expected 0 0 0", done, stall, mem_req); end
        checks++; if (mem_addr !== 32'h0 || mem_be !== 4'h0 || rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_bus: got %h %h %h expected zeros", mem_addr, mem_be, rdata); end
        step();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_late: got %b expected 0", done); end
    endtask

    initial begin
        test_reset();
        test_lb_min_latency();
        test_timeout();
        test_sh_hold();
        test_load_formats();
        test_misaligned_lw();
        test_both_strobes();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
